cache_arbiter: RTL
==================

// Module: cache_arbiter
// PURPOSE
//  Two-client arbiter for cache-line traffic. Merges I-cache (client 0) and D-cache (client 1)
//  miss/write-back requests onto one downstream line port (L2 or line adaptor).
//  Sits directly downstream of the pipelined cache cores and consumes their downstream_* interface.
//  Serves one whole line transaction at a time; downstream request signals are registered.
// PARAMETERS
//  s_offset  5    byte-offset bits per line
//  s_mask    2**s_offset  bytes per line
//  s_line    8*s_mask     line width in bits
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  c0_read        in   1       client 0 line read request (held until c0_resp)
//  c0_write       in   1       client 0 line write request (held until c0_resp)
//  c0_address     in   32      client 0 line address
//  c0_wdata       in   s_line  client 0 write line
//  c0_resp        out  1       client 0 completion pulse, 1 cycle
//  c0_rdata       out  s_line  client 0 read line, valid with c0_resp
//  c1_*           --   --      identical set for client 1
//  downstream_read     out  1       registered read request
//  downstream_write    out  1       registered write request
//  downstream_address  out  32      registered address
//  downstream_wdata    out  s_line  registered write line
//  downstream_resp     in   1       downstream completion pulse
//  downstream_rdata    in   s_line  downstream read line, valid with resp
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//   - state <= IDLE
//   - all downstream_* regs <= 0
//   - c0/c1_resp = 0 (combinational, gated by state)
//   - priority pointer <= client 1
//  FSM {IDLE, BUSY0, BUSY1}:
//   - IDLE: req0 = c0_read|c0_write, likewise req1. If any req: grant one client,
//     latch its read/write/address/wdata into the downstream regs, go to BUSY<g>.
//     Grant is registered, so downstream_read/write rise 1 cycle after the client request is seen.
//   - BUSY<g>: downstream regs hold stable. The other client's request waits.
//     On downstream_resp: c<g>_resp=1 in the same cycle (combinational);
//     c<g>_rdata=downstream_rdata; clear downstream_read/write; go to IDLE.
//   - Min spacing: 1 IDLE cycle between back-to-back grants.
//   - c*_rdata = downstream_rdata at all times; only valid while c*_resp=1.
//  Boundary rules:
//   - c*_read & c*_write both high: write wins, read is ignored.
//   - downstream_resp in IDLE: ignored, no client resp.
//   - Client drops its request while in BUSY: transaction still completes; resp still pulses once.
//   - rst mid-transaction: returns to IDLE and downstream_read/write are 0 next cycle.
//     The in-flight downstream response is then discarded.
//   - Non-granted client never sees resp.
// CONFIGURATION
//  CACHE_ARBITER_RR_EN
//   - defined: round-robin. On simultaneous requests, grant the client not served last.
//     Pointer updates at each grant.
//   - undefined: fixed priority, client 1 (D-cache) always wins ties. Pointer is unused.
// STRUCTURE
//  cache_types_pkg:
//   - s_offset/s_line constants
//   - arb_state_t enum {IDLE, BUSY0, BUSY1}
//   - line_t typedef logic [s_line-1:0]
//  Sub-module arb_grant (combinational two-way grant: req[1:0], last, rr_en -> gnt[1:0]).
//  Everything else is inline.
// TESTING
//  1. c0_read @0x0000_1000 alone -> next cycle downstream_read=1, address=0x1000;
//     resp after 3 cycles -> c0_resp=1 for 1 cycle, c0_rdata=0xA5..A5.
//  2. c0_read and c1_write @0x2000 in the same cycle (fixed priority) ->
//     c1 served first with downstream_wdata=c1_wdata; after c1_resp, 1 IDLE cycle, then c0 granted.
//  3. Under CACHE_ARBITER_RR_EN, 4 simultaneous request pairs -> grants alternate 1,0,1,0.
//  4. c1_read and c1_write both high @0x3000 -> downstream_write=1, downstream_read=0.
//  5. rst asserted while BUSY0 -> next cycle downstream_read=0 and state IDLE;
//     a late downstream_resp gives no c0_resp.
//  6. Spurious downstream_resp in IDLE -> no c*_resp and no state change.

Source files
------------

// File: rtl/cache_types_pkg.sv
// cache_types_pkg: line geometry and arbiter state encoding shared by the cache arbiter.
package cache_types_pkg;
  localparam int s_offset = 5;
  localparam int s_mask = 2 ** s_offset;
  localparam int s_line = 8 * s_mask;
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} arb_state_t;
  typedef logic [s_line-1:0] line_t;
endpackage

// File: rtl/arb_grant.sv
// arb_grant: combinational two-way grant; on a tie client 1 wins unless round-robin says it went last.
module arb_grant (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[1] = req[1] & (~req[0] | ~rr_en | ~last);
    gnt[0] = req[0] & ~gnt[1];
  end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: merges I-cache and D-cache line requests onto one registered downstream port.
// Define CACHE_ARBITER_RR_EN for round-robin tie-breaking; otherwise client 1 wins ties.
module cache_arbiter
  import cache_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_read,
  input  logic        c0_write,
  input  logic [31:0] c0_address,
  input  line_t       c0_wdata,
  output logic        c0_resp,
  output line_t       c0_rdata,
  input  logic        c1_read,
  input  logic        c1_write,
  input  logic [31:0] c1_address,
  input  line_t       c1_wdata,
  output logic        c1_resp,
  output line_t       c1_rdata,
  output logic        downstream_read,
  output logic        downstream_write,
  output logic [31:0] downstream_address,
  output line_t       downstream_wdata,
  input  logic        downstream_resp,
  input  line_t       downstream_rdata
);
`ifdef CACHE_ARBITER_RR_EN
  localparam logic rr_en = 1'b1;
`else
  localparam logic rr_en = 1'b0;
`endif
  arb_state_t state, state_next;
  logic       prio;
  logic [1:0] req, gnt;
  logic       grant;
  assign req = {c1_read | c1_write, c0_read | c0_write};
  arb_grant u_grant (
    .req  (req),
    .last (~prio),
    .rr_en(rr_en),
    .gnt  (gnt)
  );
  assign grant    = (state == IDLE) & |gnt;
  assign c0_resp  = (state == BUSY0) & downstream_resp;
  assign c1_resp  = (state == BUSY1) & downstream_resp;
  assign c0_rdata = downstream_rdata;
  assign c1_rdata = downstream_rdata;
  always_comb begin
    state_next = (state == IDLE) ? (gnt[1] ? BUSY1 : gnt[0] ? BUSY0 : IDLE)
               : downstream_resp ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      prio               <= 1'b1;
      downstream_read    <= 1'b0;
      downstream_write   <= 1'b0;
      downstream_address <= '0;
      downstream_wdata   <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        // write dominates a simultaneous read from the same client
        downstream_write   <= gnt[1] ? c1_write : c0_write;
        downstream_read    <= gnt[1] ? c1_read & ~c1_write : c0_read & ~c0_write;
        downstream_address <= gnt[1] ? c1_address : c0_address;
        downstream_wdata   <= gnt[1] ? c1_wdata : c0_wdata;
        prio               <= gnt[0];
      end else if (state != IDLE && downstream_resp) begin
        downstream_read  <= 1'b0;
        downstream_write <= 1'b0;
      end
    end
  end
endmodule
